guess_evaluator: RTL and testbench

Scores one committed four-digit guess against the loaded secret and tracks game progress for the Numberle datapath. It sits directly downstream of the keypad digit-entry stage and consumes that stage's packed 16-bit BCD guess. It produces per-digit exact and misplaced masks plus try, win and lose status for the display and LED stages. Scoring uses Wordle duplicate rules and is evaluated sequentially, one guess digit per cycle.

---
 rtl/guess_evaluator.sv | 158 +++++++++++++++
 tb/tb_guess_evaluator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/guess_evaluator.sv
// guess_evaluator: scores a committed four-digit BCD guess against the
// loaded secret using Wordle duplicate rules, one guess digit per cycle,
// and tracks tries / win / lose for the current game.
module guess_evaluator #(
    parameter int MAX_TRIES = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] secret,
    input  logic        secret_load,
    input  logic [15:0] guess,
    input  logic        submit,
    output logic        busy,
    output logic        invalid,
    output logic        result_valid,
    output logic [3:0]  exact,
    output logic [3:0]  present,
    output logic [2:0]  tries,
    output logic        win,
    output logic        lose
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        PRES  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);

    state_t          state;
    logic [15:0]     s_reg;
    logic [15:0]     g_reg;
    logic [1:0]      idx;
    logic [3:0]      used;

    logic [3:0][3:0] s_dig;
    logic [3:0][3:0] g_dig;
    logic [3:0]      g_cur;
    logic            hit;
    logic [1:0]      hit_j;
    logic            guess_bad;
    logic [3:0]      present_nxt;
    logic            win_nxt;

    assign s_dig = s_reg;
    assign g_dig = g_reg;
    assign g_cur = g_dig[idx];

    // A guess is rejected when any nibble is a non-BCD code (blank included).
    always_comb begin
        guess_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (guess[4*i +: 4] > 4'd9) guess_bad = 1'b1;
        end
    end

    // Lowest unclaimed secret position holding the current guess digit;
    // scanning high-to-low lets the lowest match win.
    always_comb begin
        hit   = 1'b0;
        hit_j = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (!used[j] && (s_dig[j] == g_cur)) begin
                hit   = 1'b1;
                hit_j = 2'(j);
            end
        end
    end

    // Present mask after scoring the current index; exact digits never
    // contribute to present.
    always_comb begin
        present_nxt = present;
        if (!exact[idx] && hit) present_nxt[idx] = 1'b1;
        win_nxt = (exact == 4'hF);
    end

    // Control FSM with all outputs registered; secret_load overrides
    // everything, including an evaluation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s_reg        <= 16'h0000;
            g_reg        <= 16'h0000;
            idx          <= 2'd0;
            used         <= 4'h0;
            exact        <= 4'h0;
            present      <= 4'h0;
            tries        <= 3'd0;
            win          <= 1'b0;
            lose         <= 1'b0;
            busy         <= 1'b0;
            invalid      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            invalid      <= 1'b0;
            result_valid <= 1'b0;
            if (secret_load) begin
                s_reg   <= secret;
                exact   <= 4'h0;
                present <= 4'h0;
                tries   <= 3'd0;
                win     <= 1'b0;
                lose    <= 1'b0;
                busy    <= 1'b0;
                idx     <= 2'd0;
                used    <= 4'h0;
                state   <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (submit) begin
                            if (guess_bad) begin
                                invalid <= 1'b1;
                            end else begin
                                g_reg <= guess;
                                busy  <= 1'b1;
                                state <= EXACT;
                            end
                        end
                    end
                    EXACT: begin
                        for (int i = 0; i < 4; i++) begin
                            exact[i] <= (g_dig[i] == s_dig[i]);
                            used[i]  <= (g_dig[i] == s_dig[i]);
                        end
                        present <= 4'h0;
                        idx     <= 2'd0;
                        state   <= PRES;
                    end
                    PRES: begin
                        present <= present_nxt;
                        if (!exact[idx] && hit) used[hit_j] <= 1'b1;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            if (tries < TRIES_MAX) tries <= tries + 3'd1;
                            win  <= win_nxt;
                            lose <= !win_nxt && ((tries + 3'd1) == TRIES_MAX);
                            if (win_nxt || ((tries + 3'd1) == TRIES_MAX))
                                state <= OVER;
                            else
                                state <= IDLE;
                        end
                    end
                    OVER: begin
                        state <= OVER;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_evaluator.sv
// Directed testbench for guess_evaluator: hand-computed scoring vectors,
// cycle-exact latency, invalid guesses, lose/win terminal state, abort and
// asynchronous reset.
module tb_guess_evaluator;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] secret = 16'h0;
    logic        secret_load = 1'b0;
    logic [15:0] guess = 16'h0;
    logic        submit = 1'b0;
    logic        busy, invalid, result_valid, win, lose;
    logic [3:0]  exact, present;
    logic [2:0]  tries;

    int errors = 0;
    int checks = 0;

    guess_evaluator #(.MAX_TRIES(6)) dut (
        .clock(clock), .reset_n(reset_n), .secret(secret),
        .secret_load(secret_load), .guess(guess), .submit(submit),
        .busy(busy), .invalid(invalid), .result_valid(result_valid),
        .exact(exact), .present(present), .tries(tries),
        .win(win), .lose(lose)
    );

    always #5 clock = ~clock;

    // Single comparison point for every check.
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] s);
        @(negedge clock);
        secret = s;
        secret_load = 1'b1;
        @(negedge clock);
        secret_load = 1'b0;
    endtask

    // Submit a valid guess and check the full 6-cycle timeline.
    task automatic submit_chk(input string tag, input logic [15:0] g,
                              input logic [3:0] ex, input logic [3:0] pr);
        @(negedge clock);
        guess = g;
        submit = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            submit = 1'b0;
            if (k == 1) chk({tag, " busy N+1"}, 16'(busy), 16'd1);
            if (k == 2) chk({tag, " exact N+2"}, 16'(exact), 16'(ex));
            if (k < 6) chk({tag, " rv early"}, 16'(result_valid), 16'd0);
        end
        chk({tag, " rv N+6"}, 16'(result_valid), 16'd1);
        chk({tag, " busy N+6"}, 16'(busy), 16'd0);
        chk({tag, " exact"}, 16'(exact), 16'(ex));
        chk({tag, " present"}, 16'(present), 16'(pr));
        @(negedge clock);
        chk({tag, " rv pulse"}, 16'(result_valid), 16'd0);
    endtask

    // Submit that must be ignored: no result, no invalid, never busy.
    task automatic submit_ignored(input string tag, input logic [15:0] g);
        int rv_seen, inv_seen, busy_seen;
        rv_seen = 0; inv_seen = 0; busy_seen = 0;
        @(negedge clock);
        guess = g;
        submit = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            submit = 1'b0;
            if (result_valid) rv_seen++;
            if (invalid) inv_seen++;
            if (busy) busy_seen++;
        end
        chk({tag, " no rv"}, 16'(rv_seen), 16'd0);
        chk({tag, " no invalid"}, 16'(inv_seen), 16'd0);
        chk({tag, " no busy"}, 16'(busy_seen), 16'd0);
    endtask

    initial begin
        int rv_seen;
        #2;
        chk("reset busy", 16'(busy), 16'd0);
        chk("reset exact", 16'(exact), 16'd0);
        chk("reset present", 16'(present), 16'd0);
        chk("reset tries", 16'(tries), 16'd0);
        chk("reset win/lose", {14'd0, win, lose}, 16'd0);
        chk("reset pulses", {14'd0, invalid, result_valid}, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Exact win, then further submits are ignored in OVER.
        load(16'h1234);
        submit_chk("win", 16'h1234, 4'hF, 4'h0);
        chk("win tries", 16'(tries), 16'd1);
        chk("win flag", {14'd0, win, lose}, 16'b10);
        submit_ignored("over", 16'h1234);
        chk("over tries", 16'(tries), 16'd1);

        // Duplicate digits in the guess claim only one secret digit.
        load(16'h5678);
        chk("load clears", {7'd0, win, lose, tries, exact}, 16'd0);
        submit_chk("dup", 16'h5555, 4'b1000, 4'b0000);
        chk("dup tries", 16'(tries), 16'd1);
        chk("dup win", {14'd0, win, lose}, 16'd0);

        // All misplaced, duplicates on both sides.
        load(16'h1123);
        submit_chk("mis", 16'h3211, 4'b0000, 4'b1111);

        // Invalid nibble: one-cycle pulse, no evaluation.
        @(negedge clock);
        guess = 16'h12F4;
        submit = 1'b1;
        @(negedge clock);
        submit = 1'b0;
        chk("inv pulse", 16'(invalid), 16'd1);
        chk("inv busy", 16'(busy), 16'd0);
        @(negedge clock);
        chk("inv pulse end", 16'(invalid), 16'd0);
        chk("inv tries", 16'(tries), 16'd1);

        // Lose after six misses.
        load(16'h0000);
        for (int t = 1; t <= 6; t++) begin
            submit_chk("lose", 16'h1111, 4'h0, 4'h0);
            chk("lose tries", 16'(tries), 16'(t));
            chk("lose flag", 16'(lose), (t == 6) ? 16'd1 : 16'd0);
        end
        chk("lose win", 16'(win), 16'd0);
        submit_ignored("lose seventh", 16'h1111);
        chk("lose tries sat", 16'(tries), 16'd6);

        // Abort by secret_load sampled at N+3.
        load(16'h1234);
        submit_chk("pre", 16'h1299, 4'b1100, 4'b0000);
        chk("pre tries", 16'(tries), 16'd1);
        rv_seen = 0;
        @(negedge clock);
        guess = 16'h1299;
        submit = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            submit = 1'b0;
            secret_load = (k == 2);
            secret = 16'h1234;
            if (result_valid) rv_seen++;
        end
        chk("abort no rv", 16'(rv_seen), 16'd0);
        chk("abort tries", 16'(tries), 16'd0);
        chk("abort busy", 16'(busy), 16'd0);

        // Asynchronous reset after edge N+3 of an evaluation.
        @(negedge clock);
        guess = 16'h1299;
        submit = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            submit = 1'b0;
        end
        chk("rst pre exact", 16'(exact), 16'b1100);
        reset_n = 1'b0;
        #1;
        chk("rst busy", 16'(busy), 16'd0);
        chk("rst masks", {8'd0, exact, present}, 16'd0);
        chk("rst status", {11'd0, tries, win, lose}, 16'd0);
        chk("rst pulses", {14'd0, invalid, result_valid}, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (result_valid) rv_seen++;
        end
        chk("rst no rv", 16'(rv_seen), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
